// File: rtl/recode_sequencer.sv
// recode_sequencer: clears the destination pre-bitstream memory, then walks the
// code-length source RAM and emits the run-length recoded code-length alphabet
// (literals 0..15, repeat codes 16/17/18 with extra bits) over valid/ready.
module recode_sequencer #(
    parameter int unsigned LEN_DEPTH = 286,
    parameter int unsigned ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len_count,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [3:0]        src_rd_data,
    output logic              clr_wr_en,
    output logic [ADDR_W-1:0] clr_wr_addr,
    output logic              sym_valid,
    output logic [4:0]        sym,
    output logic [6:0]        sym_extra,
    input  logic              sym_ready,
    output logic [ADDR_W-1:0] sym_count,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LEN_MAX  = ADDR_W'(LEN_DEPTH);
    localparam logic [ADDR_W-1:0] LEN_LAST = ADDR_W'(LEN_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_CAP = ADDR_W'(138);
    localparam logic [ADDR_W-1:0] LIT_CAP  = ADDR_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_FETCH    = 3'd2,
        ST_SCAN     = 3'd3,
        ST_EMIT_LIT = 3'd4,
        ST_EMIT_REP = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [3:0]        v_q, v_d;
    logic [ADDR_W-1:0] adv_q, adv_d;
    logic              rep_pend_q, rep_pend_d;
    logic [6:0]        rep_extra_q, rep_extra_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic              clr_en_q, clr_en_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              valid_q, valid_d;
    logic [4:0]        sym_q, sym_d;
    logic [6:0]        extra_q, extra_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Run-length limit: value cap (depends on the run value) bounded by entries left.
    logic [ADDR_W-1:0] remaining_c;
    logic [3:0]        v_eff_c;
    logic [ADDR_W-1:0] cap_c;
    logic [ADDR_W-1:0] limit_c;
    logic [ADDR_W-1:0] next_off_c;
    logic [ADDR_W-1:0] i_adv_c;

    assign remaining_c = len_q - i_q;
    assign v_eff_c     = (r_q == '0) ? src_rd_data : v_q;
    assign cap_c       = (v_eff_c == 4'd0) ? ZERO_CAP : LIT_CAP;
    assign limit_c     = (remaining_c < cap_c) ? remaining_c : cap_c;
    assign next_off_c  = r_q + ADDR_W'(2);
    assign i_adv_c     = i_q + adv_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        i_d         = i_q;
        r_d         = r_q;
        v_d         = v_q;
        adv_d       = adv_q;
        rep_pend_d  = rep_pend_q;
        rep_extra_d = rep_extra_q;
        src_addr_d  = src_addr_q;
        clr_en_d    = clr_en_q;
        clr_addr_d  = clr_addr_q;
        valid_d     = valid_q;
        sym_d       = sym_q;
        extra_d     = extra_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = (len_count > LEN_MAX) ? LEN_MAX : len_count;
                    i_d        = '0;
                    count_d    = '0;
                    busy_d     = 1'b1;
                    clr_en_d   = 1'b1;
                    clr_addr_d = '0;
                    src_addr_d = '0;
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == LEN_LAST) begin
                    clr_en_d   = 1'b0;
                    clr_addr_d = '0;
                    if (len_q == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        src_addr_d = '0;
                        state_d    = ST_FETCH;
                    end
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            ST_FETCH: begin
                // Address i is on the bus; queue i+1 if it exists so reads stream.
                r_d     = '0;
                state_d = ST_SCAN;
                if (remaining_c > ADDR_W'(1)) begin
                    src_addr_d = i_q + ADDR_W'(1);
                end
            end
            ST_SCAN: begin
                // Data for offset r arrives; a stale or mismatching word ends the run.
                if ((r_q == limit_c) || ((r_q != '0) && (src_rd_data != v_q))) begin
                    valid_d    = 1'b1;
                    rep_pend_d = 1'b0;
                    adv_d      = r_q;
                    if ((v_q == 4'd0) && (r_q >= ADDR_W'(11))) begin
                        sym_d   = 5'd18;
                        extra_d = 7'(r_q - ADDR_W'(11));
                        state_d = ST_EMIT_REP;
                    end else if ((v_q == 4'd0) && (r_q >= ADDR_W'(3))) begin
                        sym_d   = 5'd17;
                        extra_d = 7'(r_q - ADDR_W'(3));
                        state_d = ST_EMIT_REP;
                    end else if ((v_q != 4'd0) && (r_q >= ADDR_W'(4))) begin
                        sym_d       = {1'b0, v_q};
                        extra_d     = '0;
                        rep_pend_d  = 1'b1;
                        rep_extra_d = 7'(r_q - ADDR_W'(4));
                        state_d     = ST_EMIT_LIT;
                    end else begin
                        sym_d   = {1'b0, v_q};
                        extra_d = '0;
                        adv_d   = ADDR_W'(1);
                        state_d = ST_EMIT_LIT;
                    end
                end else begin
                    if (r_q == '0) begin
                        v_d = src_rd_data;
                    end
                    r_d = r_q + ADDR_W'(1);
                    if (next_off_c < limit_c) begin
                        src_addr_d = i_q + next_off_c;
                    end
                end
            end
            ST_EMIT_LIT, ST_EMIT_REP: begin
                if (valid_q && sym_ready) begin
                    count_d = count_q + ADDR_W'(1);
                    valid_d = 1'b0;
                    if (rep_pend_q) begin
                        rep_pend_d = 1'b0;
                        valid_d    = 1'b1;
                        sym_d      = 5'd16;
                        extra_d    = rep_extra_q;
                        state_d    = ST_EMIT_REP;
                    end else begin
                        i_d = i_adv_c;
                        if (i_adv_c == len_q) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            src_addr_d = i_adv_c;
                            state_d    = ST_FETCH;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            i_q         <= '0;
            r_q         <= '0;
            v_q         <= '0;
            adv_q       <= '0;
            rep_pend_q  <= 1'b0;
            rep_extra_q <= '0;
            src_addr_q  <= '0;
            clr_en_q    <= 1'b0;
            clr_addr_q  <= '0;
            valid_q     <= 1'b0;
            sym_q       <= '0;
            extra_q     <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            i_q         <= i_d;
            r_q         <= r_d;
            v_q         <= v_d;
            adv_q       <= adv_d;
            rep_pend_q  <= rep_pend_d;
            rep_extra_q <= rep_extra_d;
            src_addr_q  <= src_addr_d;
            clr_en_q    <= clr_en_d;
            clr_addr_q  <= clr_addr_d;
            valid_q     <= valid_d;
            sym_q       <= sym_d;
            extra_q     <= extra_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign src_rd_addr = src_addr_q;
    assign clr_wr_en   = clr_en_q;
    assign clr_wr_addr = clr_addr_q;
    assign sym_valid   = valid_q;
    assign sym         = sym_q;
    assign sym_extra   = extra_q;
    assign sym_count   = count_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_recode_sequencer.sv
// Scoreboard bench for recode_sequencer: expected symbols are queued per job,
// a negedge monitor pops and compares every accepted symbol.
module tb_recode_sequencer;

    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 286;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] len_count;
    logic [AW-1:0] src_rd_addr;
    logic [3:0]    src_rd_data;
    logic          clr_wr_en;
    logic [AW-1:0] clr_wr_addr;
    logic          sym_valid;
    logic [4:0]    sym;
    logic [6:0]    sym_extra;
    logic          sym_ready;
    logic [AW-1:0] sym_count;
    logic          busy;
    logic          done;

    recode_sequencer #(.LEN_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .len_count(len_count),
        .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
        .clr_wr_en(clr_wr_en), .clr_wr_addr(clr_wr_addr),
        .sym_valid(sym_valid), .sym(sym), .sym_extra(sym_extra),
        .sym_ready(sym_ready), .sym_count(sym_count),
        .busy(busy), .done(done)
    );

    int          tests;
    int          fails;
    int          clr_cnt;
    int          done_cnt;
    int          max_rd;
    bit          ready_toggle;
    bit          prev_pend;
    logic [11:0] prev_word;
    logic [11:0] exp_q[$];
    logic [3:0]  src_mem[0:511];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_sym(input int s, input int e);
        exp_q.push_back({5'(s), 7'(e)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, sym_valid, 0);
        check({tag, "_sym"}, {sym, sym_extra}, 0);
        check({tag, "_clr"}, {clr_wr_en, clr_wr_addr}, 0);
        check({tag, "_rdaddr"}, src_rd_addr, 0);
        check({tag, "_count"}, sym_count, 0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source RAM model: data valid one cycle after the address.
    initial begin
        src_rd_data = '0;
        forever begin
            @(posedge clk);
            src_rd_data <= src_mem[src_rd_addr];
        end
    end

    // Consumer ready: held high, or toggling each cycle.
    initial begin
        sym_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_toggle) sym_ready = ~sym_ready;
            else sym_ready = 1'b1;
        end
    end

    // Monitor: clear sweep order, read address range, hold-until-accept, symbol scoreboard.
    initial begin
        logic [11:0] w;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pend = 1'b0;
                continue;
            end
            if (clr_wr_en) begin
                if (int'(clr_wr_addr) != clr_cnt) check("clr_addr_seq", clr_wr_addr, clr_cnt);
                clr_cnt++;
            end
            if (busy && !clr_wr_en && int'(src_rd_addr) > max_rd) max_rd = src_rd_addr;
            if (prev_pend) begin
                check("hold_valid", sym_valid, 1);
                check("hold_word", {sym, sym_extra}, prev_word);
            end
            if (sym_valid && sym_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_sym: got sym %0d extra %0d expected none", sym, sym_extra);
                end else begin
                    w = exp_q.pop_front();
                    check("sym", sym, w[11:7]);
                    check("sym_extra", sym_extra, w[6:0]);
                end
            end
            prev_pend = sym_valid && !sym_ready;
            prev_word = {sym, sym_extra};
            if (done) done_cnt++;
        end
    end

    task automatic issue_start(input int len);
        @(posedge clk);
        #1;
        len_count = AW'(len);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_job(input string tag, input int len, input int exp_cnt,
                           input int exp_max_rd, input bit poke);
        int n;
        int d0;
        clr_cnt = 0;
        max_rd  = 0;
        d0      = done_cnt;
        issue_start(len);
        @(negedge clk);
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_clr"}, {clr_wr_en, clr_wr_addr}, {1'b1, 9'd0});
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
            if (poke && n == 50) begin
                len_count = AW'(400);
                start     = 1'b1;
            end else if (poke && n == 51) begin
                start = 1'b0;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done expected done within 5000 cycles", tag);
        end
        check({tag, "_done_busy"}, busy, 0);
        check({tag, "_sym_count"}, sym_count, exp_cnt);
        check({tag, "_clr_writes"}, clr_cnt, DEPTH);
        check({tag, "_max_rd"}, max_rd, exp_max_rd);
        check({tag, "_pending_exp"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_count_hold"}, sym_count, exp_cnt);
    endtask

    task automatic load_pattern8();
        for (int k = 0; k < 512; k++) src_mem[k] = 4'd0;
        src_mem[2] = 4'd7;
        src_mem[7] = 4'd3;
        src_mem[8] = 4'd9;
    endtask

    initial begin
        int n;
        int d0;
        tests        = 0;
        fails        = 0;
        clr_cnt      = 0;
        done_cnt     = 0;
        max_rd       = 0;
        ready_toggle = 1'b0;
        prev_pend    = 1'b0;
        prev_word    = '0;
        start        = 1'b0;
        len_count    = '0;
        reset        = 1'b1;
        for (int k = 0; k < 512; k++) src_mem[k] = 4'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Empty job: clear sweep only.
        run_job("len0", 0, 0, 0, 1'b0);

        // 139 zeros, with a mid-job start that must be ignored.
        push_sym(18, 127);
        push_sym(0, 0);
        run_job("zeros139", 139, 2, 138, 1'b1);

        // Ten fives.
        for (int k = 0; k < 512; k++) src_mem[k] = 4'd1;
        for (int k = 0; k < 10; k++) src_mem[k] = 4'd5;
        push_sym(5, 0);
        push_sym(16, 3);
        push_sym(5, 0);
        push_sym(5, 0);
        push_sym(5, 0);
        run_job("fives", 10, 5, 9, 1'b0);

        // Mixed pattern with a toggling consumer.
        load_pattern8();
        ready_toggle = 1'b1;
        push_sym(0, 0);
        push_sym(0, 0);
        push_sym(7, 0);
        push_sym(17, 1);
        push_sym(3, 0);
        run_job("mixed", 8, 5, 7, 1'b0);
        ready_toggle = 1'b0;

        // Reset in the middle of the clear sweep.
        clr_cnt = 0;
        d0      = done_cnt;
        issue_start(8);
        n = 0;
        while (!(clr_wr_en && clr_wr_addr == AW'(100)) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_at_addr100", clr_wr_addr, 100);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        push_sym(0, 0);
        push_sym(0, 0);
        push_sym(7, 0);
        push_sym(17, 1);
        push_sym(3, 0);
        run_job("rerun", 8, 5, 7, 1'b0);

        // Oversized length clamps to the memory depth.
        for (int k = 0; k < 512; k++) src_mem[k] = (k < int'(DEPTH)) ? 4'd0 : 4'd9;
        push_sym(18, 127);
        push_sym(18, 127);
        push_sym(17, 7);
        run_job("clamp", 400, 3, 285, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/recode_sequencer.md
# recode_sequencer

Controller for the code-length recode stage of the deflate compressor. On `start` it clears the destination pre-bitstream memory with a zero sweep. It then walks the code-length source RAM and emits the run-length recoded code-length alphabet: symbols 0..15 are literals, 16/17/18 are repeat codes with extra bits. Symbols leave through a valid/ready handshake to the bitstream packer.

## Interface
- `LEN_DEPTH`, 286: depth of the destination memory cleared by the sweep; also the maximum `len_count`.
- `ADDR_W`, 9: address width for source read and clear write.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  one-cycle job request, honoured only in IDLE.
- `len_count`  in  ADDR_W  number of code lengths to recode; latched on accepted `start`.
- `src_rd_addr`  out  ADDR_W  source code-length RAM read address.
- `src_rd_data`  in  4  source code length; valid exactly one cycle after address.
- `clr_wr_en`  out  1  destination clear write strobe; data is implicitly zero.
- `clr_wr_addr`  out  ADDR_W  destination clear address.
- `sym_valid`  out  1  recoded symbol available.
- `sym`  out  5  recoded symbol, 0..18.
- `sym_extra`  out  7  extra-bit value; 0 for literals.
- `sym_ready`  in  1  consumer accepts on the edge where `sym_valid && sym_ready`.
- `sym_count`  out  ADDR_W  symbols emitted in the current job.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse at job end.

## Operation
- States: IDLE, CLEAR, FETCH, SCAN, EMIT_LIT, EMIT_REP, DONE.
- IDLE: `start` latches `len_count`, clamped to LEN_DEPTH. It clears `sym_count` and moves to CLEAR. `start` in any other state is ignored.
- CLEAR: writes addresses 0..LEN_DEPTH-1 at one per cycle. After the last write the controller goes to FETCH, or to DONE if `len_count`==0.
- FETCH/SCAN: the run starts at index i with value v. It counts r consecutive entries equal to v.
  - r is capped at 138 if v==0, and at 7 if v!=0.
  - r is also capped at the remaining count (`len_count` - i).
  - Reads are issued one per cycle. The first mismatching read is discarded and is not consumed.
- Run decision:
  - v==0, r>=11: emit 18 with extra r-11. Advance r.
  - v==0, 3<=r<=10: emit 17 with extra r-3. Advance r.
  - v!=0, r>=4: emit literal v, then 16 with extra r-4. Advance r.
  - Otherwise: emit literal v and advance 1. The next run is rescanned from i+1.
- EMIT_LIT/EMIT_REP hold `sym_valid` with `sym`/`sym_extra` stable until accepted. `sym_count` increments on every accepted symbol.
- After the final emit, when i==`len_count`, the controller goes to DONE. DONE pulses `done`, drops `busy` and returns to IDLE.
- Arithmetic: i, r and `sym_count` are ADDR_W unsigned and do not wrap, because `len_count` is clamped. `sym_extra` is zero-extended to 7 bits.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset at any cycle, including mid-CLEAR or with `sym_valid` high, aborts the job. It forces reset values on the next edge and does not pulse `done`.
- Start: cycle after `start`, `busy`=1 and `clr_wr_en`=1 with `clr_wr_addr`=0. The last clear write is LEN_DEPTH cycles later.
- Scan latency: a run of r entries takes r+2 cycles from first address issue to `sym_valid`=1.
- Handshake:
  - `sym_valid` is registered and never deasserts without acceptance.
  - `sym_ready` may be high before `sym_valid`.
  - With `sym_ready` held high, the 16 following a literal is presented on the cycle after the literal is accepted.
- Done: `done`=1 and `busy`=0 on the cycle after the last symbol is accepted. `sym_count` holds until the next `start`.
- `src_rd_addr` and `clr_*` are never active in the same cycle.

## Test plan
- `len_count`=0, start → 286 clear writes at addr 0..285, then `done` with `sym_count`=0 and no `sym_valid`.
- Source of 139 zeros → symbols 18(extra 127) then 0; `sym_count`=2.
- Source [5×10] → 5, 16(extra 3), 5, 5, 5; `sym_count`=5.
- Source [0,0,7,0,0,0,0,3] → 0, 0, 7, 17(extra 1), 3, with `sym_ready` toggling every cycle; every symbol stable until accepted.
- Reset asserted during CLEAR at `clr_wr_addr`=100 → next cycle all outputs 0, no `done`. A new start runs a full 286-write clear.
- `start` pulsed while `busy` and `len_count`=400 → mid-job start ignored; a later job with `len_count`=400 clamps to 286 reads (`src_rd_addr` max 285).
